// File: rtl/aes_defs.sv
// Shared AES constants, FSM state type and GF(2^8) helpers.
package aes_defs;

    localparam int unsigned AES_NK     = 4;
    localparam int unsigned AES_NR     = 10;
    localparam int unsigned AES_NWORDS = 44;

    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] XTIME_POLY = 8'h1B;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } aes_state_e;

    // Multiply by x in GF(2^8) with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? XTIME_POLY : 8'h00);
    endfunction

    // Shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box: field inverse followed by the affine map.
module aes_sbox
    import aes_defs::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] sub_byte
);

    logic [7:0] inv;

    // Inverse, then b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    always_comb begin
        inv      = gf_inv(in_byte);
        sub_byte = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: streams w[0..43] one word per handshake.
module aes_key_expand
    import aes_defs::*;
#(
    parameter int unsigned NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [31:0]  rk_word,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_round,
    output logic [1:0]   rk_col,
    output logic         rk_last,
    output logic         busy,
    output logic         done
);

    localparam int unsigned LastIdxInt = AES_NK * (NR + 1) - 1;
    localparam logic [5:0]  LastIdx    = 6'(LastIdxInt);

    if (NR != AES_NR) begin : g_nr_check
        $error("aes_key_expand: only NR=10 is supported");
    end

    aes_state_e  state_q, state_d;
    logic [31:0] win_q [4];
    logic [31:0] win_d [4];
    logic [31:0] word_q, word_d;
    logic [5:0]  idx_q, idx_d;
    logic [7:0]  rcon_q, rcon_d;
    logic        done_q, done_d;

    logic [5:0]  next_idx;
    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic [31:0] new_word;

    // win_q[3] is the newest word; RotWord moves its top byte to the bottom.
    assign rot_word = {win_q[3][23:0], win_q[3][31:24]};
    assign next_idx = idx_q + 6'd1;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_word[8*b +: 8]),
            .sub_byte (sub_word[8*b +: 8])
        );
    end

    // Next schedule word from w[i-4] (win_q[0]) and w[i-1] (win_q[3]).
    always_comb begin
        if (next_idx[1:0] == 2'd0) begin
            new_word = win_q[0] ^ sub_word ^ {rcon_q, 24'h000000};
        end else begin
            new_word = win_q[0] ^ win_q[3];
        end
    end

    // Next-state logic: load key on start, advance one word per handshake.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        word_d  = word_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StRun;
                    win_d[0] = key_in[127:96];
                    win_d[1] = key_in[95:64];
                    win_d[2] = key_in[63:32];
                    win_d[3] = key_in[31:0];
                    word_d   = key_in[127:96];
                    idx_d    = 6'd0;
                    rcon_d   = RCON_INIT;
                end
            end
            StRun: begin
                if (rk_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = next_idx;
                        if (next_idx < 6'd4) begin
                            // First four words come straight from the key.
                            word_d = win_q[next_idx[1:0]];
                        end else begin
                            word_d   = new_word;
                            win_d[0] = win_q[1];
                            win_d[1] = win_q[2];
                            win_d[2] = win_q[3];
                            win_d[3] = new_word;
                            if (next_idx[1:0] == 2'd0) rcon_d = xtime(rcon_q);
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            for (int k = 0; k < 4; k++) win_q[k] <= 32'h0;
            word_q  <= 32'h0;
            idx_q   <= 6'd0;
            rcon_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    assign rk_word  = word_q;
    assign rk_valid = (state_q == StRun);
    assign busy     = (state_q == StRun);
    assign rk_round = idx_q[5:2];
    assign rk_col   = idx_q[1:0];
    assign rk_last  = (state_q == StRun) && (idx_q == LastIdx);
    assign done     = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: table-driven key-schedule model plus directed vectors.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic [31:0]  rk_word;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_round;
    logic [1:0]   rk_col;
    logic         rk_last;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KeyFips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KeyZero = 128'h0;
    localparam logic [127:0] KeySeq  = 128'h000102030405060708090a0b0c0d0e0f;

    aes_key_expand dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .rk_word  (rk_word),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_round (rk_round),
        .rk_col   (rk_col),
        .rk_last  (rk_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // FIPS-197 S-box, one 16-entry row per element.
    logic [127:0] sbox_rows [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [127:0] row;
        row = sbox_rows[x[7:4]];
        return row[127 - 8*x[3:0] -: 8];
    endfunction

    // Full FIPS-197 expansion, returning word idx.
    function automatic logic [31:0] expand_word(input logic [127:0] key, input int idx);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])}
                    ^ {rcon_tab[i/4 - 1], 24'h000000};
            end
            w[i] = w[i-4] ^ t;
        end
        return w[idx];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level model of the stream.
    logic         m_known  = 1'b0;
    logic         m_active = 1'b0;
    logic         m_done   = 1'b0;
    logic         m_zero   = 1'b1;
    int           m_idx    = 0;
    logic [127:0] m_key    = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_known  <= 1'b1;
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_zero   <= 1'b1;
            m_idx    <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_active) begin
                if (start) begin
                    m_active <= 1'b1;
                    m_idx    <= 0;
                    m_key    <= key_in;
                    m_zero   <= 1'b0;
                end
            end else if (rk_ready) begin
                if (m_idx == 43) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end else begin
                    m_idx <= m_idx + 1;
                end
            end
        end
    end

    // Compare DUT against the model every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (m_known) begin
            chk("rk_valid", {31'b0, rk_valid}, {31'b0, m_active});
            chk("busy", {31'b0, busy}, {31'b0, m_active});
            chk("done", {31'b0, done}, {31'b0, m_done});
            chk("rk_word", rk_word, m_zero ? 32'h0 : expand_word(m_key, m_idx));
            if (m_active) begin
                chk("rk_round", {28'b0, rk_round}, 32'(m_idx / 4));
                chk("rk_col", {30'b0, rk_col}, 32'(m_idx % 4));
                chk("rk_last", {31'b0, rk_last}, {31'b0, (m_idx == 43)});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic skip(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic begin_stream(input logic [127:0] key);
        key_in = key;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic run_to_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("done_reached", {31'b0, done}, 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        key_in   = '0;
        rk_ready = 1'b1;

        chk("model_w4", expand_word(KeyFips, 4), 32'ha0fafe17);
        chk("model_w8", expand_word(KeyFips, 8), 32'hf2c295f2);
        chk("model_w40", expand_word(KeyFips, 40), 32'hd014f9a8);
        chk("model_w43", expand_word(KeyFips, 43), 32'hb6630ca6);
        chk("model_zero_w40", expand_word(KeyZero, 40), 32'hb4ef5bcb);

        skip(3);
        rst_n = 1'b1;
        step();
        chk("rst_word", rk_word, 32'h0);
        chk("rst_flags", {26'b0, rk_valid, busy, done, rk_last, rk_col}, 32'h0);
        chk("rst_round", {28'b0, rk_round}, 32'h0);

        // FIPS-197 A.1 with rk_ready high: w_k lands in cycle t+1+k.
        begin_stream(KeyFips);
        chk("fips_w0", rk_word, 32'h2b7e1516);
        skip(4);
        chk("fips_w4", rk_word, 32'ha0fafe17);
        skip(4);
        chk("fips_w8", rk_word, 32'hf2c295f2);
        skip(32);
        chk("fips_w40", rk_word, 32'hd014f9a8);
        skip(3);
        chk("fips_w43", rk_word, 32'hb6630ca6);
        chk("fips_last", {31'b0, rk_last}, 32'h1);
        chk("fips_round10", {28'b0, rk_round}, 32'd10);
        step();
        chk("fips_done_t45", {29'b0, done, rk_valid, busy}, 32'h4);
        chk("fips_hold_w43", rk_word, 32'hb6630ca6);
        step();
        chk("fips_done_pulse", {31'b0, done}, 32'h0);

        // All-zero key.
        begin_stream(KeyZero);
        skip(4);
        chk("zero_w4", rk_word, 32'h62636363);
        skip(36);
        chk("zero_w40", rk_word, 32'hb4ef5bcb);
        skip(3);
        chk("zero_w43", rk_word, 32'h6f8f188e);
        run_to_done();
        step();

        // Back-pressure on w4.
        begin_stream(KeyFips);
        skip(4);
        rk_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_word", rk_word, 32'ha0fafe17);
            chk("bp_round", {28'b0, rk_round}, 32'd1);
            step();
        end
        rk_ready = 1'b1;
        step();
        chk("bp_w5", rk_word, 32'h88542cb1);
        run_to_done();
        step();

        // start while busy at w10 with another key is ignored.
        begin_stream(KeyFips);
        skip(10);
        key_in = KeyZero;
        start  = 1'b1;
        step();
        start  = 1'b0;
        chk("busy_start_round", {28'b0, rk_round}, 32'd2);
        chk("busy_start_col", {30'b0, rk_col}, 32'd3);
        run_to_done();
        step();

        // Reset mid-stream at w20: outputs clear, no done pulse.
        begin_stream(KeyFips);
        skip(20);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_word", rk_word, 32'h0);
        chk("midrst_flags", {26'b0, rk_valid, busy, done, rk_last, rk_col}, 32'h0);
        chk("midrst_round", {28'b0, rk_round}, 32'h0);
        step();
        chk("midrst_no_done", {31'b0, done}, 32'h0);
        begin_stream(KeyFips);
        chk("fresh_w0", rk_word, 32'h2b7e1516);
        run_to_done();

        // start in the done cycle begins a new stream right away.
        key_in = KeySeq;
        start  = 1'b1;
        step();
        start  = 1'b0;
        chk("b2b_valid", {31'b0, rk_valid}, 32'h1);
        chk("b2b_w0", rk_word, 32'h00010203);
        run_to_done();
        skip(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Sequential AES-128 key-schedule engine. Expands a 128-bit cipher key into the 44 round-key words w[0..43] defined by FIPS-197.
- Streams the words one per handshake, in order, to the round datapath, where they feed the round_key input of the AddRoundKey stage.
- Output is word-oriented (32-bit), matching the column-at-a-time datapath.

Parameters:
- NR, 10, number of rounds. Total words = 4*(NR+1). Only 10 is supported; any other value is a configuration error.

Ports:
- clk  input  1  single clock, rising-edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  one-cycle request to begin expansion; sampled only when busy=0
- key_in  input  128  cipher key; key_in[127:96]=w0 … key_in[31:0]=w3; sampled on the start cycle only
- rk_word  output  32  current round-key word; byte 0 in [31:24]
- rk_valid  output  1  rk_word is valid
- rk_ready  input  1  consumer accepts rk_word when rk_valid&rk_ready
- rk_round  output  4  round index of rk_word (i/4), 0..10
- rk_col  output  2  column index of rk_word (i%4)
- rk_last  output  1  high with w43
- busy  output  1  expansion in progress
- done  output  1  one-cycle pulse after w43 is accepted

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE. rk_word=0, rk_valid=0, rk_round=0, rk_col=0, rk_last=0, busy=0, done=0. Internal window and rcon are cleared. Reset has priority over every other input, including mid-stream; the partial stream is abandoned and no done pulse is issued.
- States: IDLE, RUN.
- IDLE:
  - If start=1 at edge t: latch key_in, word index i=0, rcon=0x01, go to RUN.
  - In cycle t+1: rk_valid=1, busy=1, rk_word=w0, rk_round=0, rk_col=0.
- RUN:
  - A handshake (rk_valid&rk_ready) at an edge advances i by 1. rk_word, rk_round, rk_col and rk_last update in the next cycle.
  - Without a handshake, all outputs and internal registers hold; rk_word is stable under back-pressure.
  - start is ignored while busy=1.
- Word generation for i>=4:
  - If i%4 != 0: w[i] = w[i-4] ^ w[i-1].
  - If i%4 == 0: temp = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}, then w[i] = w[i-4] ^ temp.
  - RotWord: {b1,b2,b3,b0}.
  - rcon advances by GF(2^8) xtime (shift left 1; if bit7 was set, XOR 0x1B) after each i%4==0 word is accepted. Sequence: 01,02,04,08,10,20,40,80,1B,36.
- Window storage: 4-word sliding window holding w[i-4..i-1]. The next word is computed combinationally from the window and registered into rk_word on the handshake. Latency is 0 extra cycles, so the block sustains 1 word/clock with rk_ready held high.
- rk_last=1 exactly when i=43.
- End of stream:
  - Handshake on w43 at edge e: state returns to IDLE.
  - In cycle e+1: rk_valid=0, busy=0, done=1 (one cycle only).
  - rk_word holds w43 until the next start.
- start asserted in the same cycle as done: accepted, because busy=0 in that cycle. A new stream begins the cycle after.
- With rk_ready tied high, start at edge t gives w43 presented in cycle t+44 and done in cycle t+45.

Decomposition:
- Shared package/header aes_defs:
  - AES_NK=4, AES_NR=10, AES_NWORDS=44
  - RCON_INIT=8'h01, XTIME_POLY=8'h1B
  - state encodings IDLE/RUN
- Sub-module aes_sbox: combinational 8-bit forward S-box. Instantiated 4 times for SubWord and reused later by the SubBytes stage.

Test Plan:
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 → w0=2b7e1516, w4=a0fafe17, w8=f2c295f2, w40=d014f9a8, w43=b6630ca6 with rk_last=1 and rk_round=10. done pulses in cycle t+45.
- All-zero key → w4=62636363, w40=b4ef5bcb, w43=6f8f188e. All 44 words match the software model.
- Back-pressure: hold rk_ready=0 for 5 cycles while w4 is presented → rk_word stays a0fafe17 and rk_round=1 throughout. Stream resumes with w5=88542cb1.
- start pulse while busy (at w10) with a different key → ignored; the stream continues with the original key's values.
- rst_n=0 for 1 cycle at w20 → next cycle all outputs are 0 and no done pulse. A fresh start then reproduces w0..w43 correctly.
- start asserted in the done cycle → a second stream begins; rk_valid rises the cycle after with w0 of the new key.
